// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings and default timing constants for the CPU execution sequencer.
package cpu_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_STEP  = 2'b10;
   localparam logic [1:0] ST_BREAK = 2'b11;

   localparam int unsigned RUN_DIV_DEF    = 25_000_000;
   localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

   // Width of a counter that spans 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer producing a one-cycle pulse per accepted press.
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic evt
);

   localparam int unsigned CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level;
   logic          level_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         evt     <= 1'b0;
      end else begin
         sync    <= {sync[0], btn};
         level_d <= level;
         evt     <= level & ~level_d;
         // Any cycle where the input agrees with the accepted level restarts the count.
         if (sync[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer: issues single-cycle cpu_en pulses in free-run, single-step or breakpoint-halt modes.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned RUN_DIV    = RUN_DIV_DEF,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned PC_W       = 8
) (
   input  logic            clk_50m,
   input  logic            reset,
   input  logic            run_sw,
   input  logic            step_btn,
   input  logic            bp_en,
   input  logic [PC_W-1:0] bp_addr,
   input  logic [PC_W-1:0] pc,
   output logic            cpu_en,
   output logic [1:0]      state,
   output logic            halted,
   output logic            bp_hit,
   output logic [15:0]     instr_count
);

   localparam int unsigned PW = cnt_width(RUN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);

   logic          step_evt;
   logic [1:0]    run_sync;
   logic          run_s;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_nx;
   logic [1:0]    state_nx;
   logic          en_nx;

   btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_step_deb (
      .clk   (clk_50m),
      .reset (reset),
      .btn   (step_btn),
      .evt   (step_evt)
   );

   assign run_s = run_sync[1];

   always_comb begin
      state_nx = state;
      presc_nx = presc;
      en_nx    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (step_evt) begin
               state_nx = ST_STEP;
               en_nx    = 1'b1;
            end else if (run_s) begin
               state_nx = ST_RUN;
               presc_nx = '0;
            end
         end
         ST_RUN: begin
            if (!run_s) begin
               state_nx = ST_IDLE;
               presc_nx = '0;
            end else if (presc == PRESC_LAST) begin
               presc_nx = '0;
               if (bp_en && (pc == bp_addr)) begin
                  state_nx = ST_BREAK;
               end else begin
                  en_nx = 1'b1;
               end
            end else begin
               presc_nx = presc + 1'b1;
            end
         end
         ST_STEP: begin
            state_nx = ST_IDLE;
         end
         default: begin
            if (!run_s) begin
               state_nx = ST_IDLE;
            end else if (step_evt) begin
               state_nx = ST_STEP;
               en_nx    = 1'b1;
            end
         end
      endcase
   end

   // Status flags are registered from the next state so they line up with the state output.
   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         run_sync    <= '0;
         state       <= ST_IDLE;
         presc       <= '0;
         cpu_en      <= 1'b0;
         halted      <= 1'b1;
         bp_hit      <= 1'b0;
         instr_count <= '0;
      end else begin
         run_sync <= {run_sync[0], run_sw};
         state    <= state_nx;
         presc    <= presc_nx;
         cpu_en   <= en_nx;
         halted   <= (state_nx == ST_IDLE) || (state_nx == ST_BREAK);
         bp_hit   <= (state_nx == ST_BREAK);
         if (en_nx) begin
            instr_count <= instr_count + 16'd1;
         end
      end
   end

endmodule
